unsigned_16by8_seq_divider: RTL and testbench

- Sequential unsigned restoring divider; the inverse direction of the team's 8x8 unsigned multipliers.
- Takes a 2W-bit product-style dividend and a W-bit divisor. Returns a W-bit quotient and a W-bit remainder.
- Used in the characterization datapath to recover one multiplier operand from a product, and as the exact-division reference.
- Valid/ready handshake on input and output; one quotient bit per clock.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 28 ++
 rtl/unsigned_16by8_seq_divider.sv | 144 ++++++++++++++
 tb/tb_unsigned_16by8_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_next,
  output logic             qbit
);

  // Trial is one bit wider than the divisor so the shifted-out MSB still takes part in the compare
  logic [WIDTH:0] trial;
  logic [WIDTH:0] divisor_ext;

  // Restoring subtract-or-keep decision
  always_comb begin
    trial       = {prem, bit_in};
    divisor_ext = {1'b0, divisor};
    prem_next   = trial[WIDTH-1:0];
    qbit        = 1'b0;
    if (trial >= divisor_ext) begin
      prem_next = WIDTH'(trial - divisor_ext);
      qbit      = 1'b1;
    end
  end

endmodule

// File: rtl/unsigned_16by8_seq_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
module unsigned_16by8_seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dsh_q, dsh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_d, out_valid_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             div_zero_d, overflow_d;

  logic [WIDTH-1:0] prem_next;
  logic             qbit;

  // The remainder register doubles as the partial remainder while BUSY
  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (remainder),
    .bit_in    (dsh_q[WIDTH-1]),
    .divisor   (divisor_q),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      dsh_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      dsh_q     <= dsh_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      div_zero  <= div_zero_d;
      overflow  <= overflow_d;
    end
  end

  // Next-state, handshake and restoring-step sequencing
  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    dsh_d       = dsh_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    quotient_d  = quotient;
    remainder_d = remainder;
    div_zero_d  = div_zero;
    overflow_d  = overflow;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          in_ready_d = 1'b0;
          divisor_d  = divisor;
          state_d    = BUSY;
          if (divisor == '0) begin
            div_zero_d  = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[WIDTH-1:0];
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            overflow_d  = 1'b1;
            quotient_d  = '1;
            remainder_d = '1;
          end else begin
            remainder_d = dividend[2*WIDTH-1:WIDTH];
            dsh_d       = dividend[WIDTH-1:0];
            quotient_d  = '0;
            cnt_d       = CNT_W'(WIDTH - 1);
          end
        end
      end

      BUSY: begin
        if (div_zero || overflow) begin
          // Fast-path result is already loaded; spend one cycle and publish it
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          remainder_d = prem_next;
          quotient_d  = {quotient[WIDTH-2:0], qbit};
          dsh_d       = {dsh_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      DONE: begin
        if (out_valid && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          div_zero_d  = 1'b0;
          overflow_d  = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        div_zero_d  = 1'b0;
        overflow_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_unsigned_16by8_seq_divider.sv
// Self-checking bench for the sequential unsigned divider.
module tb_unsigned_16by8_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  unsigned_16by8_seq_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    int          stall;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Golden model by plain integer division
  function automatic logic [17:0] model(input logic [15:0] dd, input logic [7:0] dv);
    int unsigned q;
    int unsigned r;
    if (dv == 8'd0) return {8'hFF, dd[7:0], 1'b1, 1'b0};
    q = 32'(dd) / 32'(dv);
    r = 32'(dd) % 32'(dv);
    if (q > 32'd255) return {8'hFF, 8'hFF, 1'b0, 1'b1};
    return {8'(q), 8'(r), 2'b00};
  endfunction

  // One full transaction: issue, wait for result, stall, handshake
  task automatic do_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                       input int stall, input logic [17:0] exp, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      out_ready = out_valid ? 1'b0 : 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'({quotient, remainder, div_zero, overflow}), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
      check({tag, "_stall"}, 64'({out_valid, in_ready, quotient, remainder, div_zero, overflow}),
            64'({1'b1, 1'b0, exp}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_hs"}, 64'({out_valid, in_ready, div_zero, overflow}), 64'(4'b0100));
  endtask

  initial begin
    logic [15:0] rdd;
    logic [7:0]  rdv;
    logic [7:0]  hi;
    logic [17:0] e;

    vecs[0] = '{16'h1234, 8'h56, 5, 8'h36, 8'h10, 1'b0, 1'b0, 8};
    vecs[1] = '{16'hFE01, 8'hFF, 0, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[2] = '{16'h00FF, 8'h01, 1, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[3] = '{16'h1000, 8'h10, 2, 8'hFF, 8'hFF, 1'b0, 1'b1, 1};
    vecs[4] = '{16'hABCD, 8'h00, 0, 8'hFF, 8'hCD, 1'b1, 1'b0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    check("reset_hold", 64'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
          64'({1'b1, 1'b0, 16'h0000, 2'b00}));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", 64'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
          64'({1'b1, 1'b0, 16'h0000, 2'b00}));

    for (int i = 0; i < 5; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].stall,
            {vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov}, vecs[i].lat);
    end

    // Abort mid-computation with reset, then confirm a clean next operation
    in_valid = 1'b1;
    dividend = 16'h1234;
    divisor  = 8'h56;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy", 64'({in_ready, out_valid}), 64'(2'b00));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_reset_vals", 64'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
          64'({1'b1, 1'b0, 16'h0000, 2'b00}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after_abort", 16'h0064, 8'h07, 1, {8'h0E, 8'h02, 2'b00}, 8);

    // Randomized traffic against the arithmetic model
    for (int i = 0; i < 3000; i++) begin
      rdd = 16'($urandom);
      hi  = rdd[15:8];
      if ($urandom_range(0, 31) == 0)
        rdv = 8'h00;
      else if ($urandom_range(0, 3) == 0 || hi == 8'hFF)
        rdv = 8'($urandom);
      else
        rdv = 8'(32'(hi) + 1 + $urandom_range(0, 254 - 32'(hi)));
      e = model(rdd, rdv);
      do_op("rand", rdd, rdv, $urandom_range(0, 3), e, (e[1:0] != 2'b00) ? 1 : 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
